// File: rtl/cpu_types_pkg.sv
// Shared types for the request sequencing logic of the stalling MIPS core.
package cpu_types_pkg;

  // Sequencer states: fetching an instruction, waiting on a data access,
  // or parked after a HALT instruction.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } reqstate_t;

  // Kind of data access latched when an instruction leaves FETCH.
  typedef struct packed {
    logic rd;
    logic wr;
  } dreq_t;

  // Collapse the decode strobes into the access actually issued: a
  // simultaneous load and store is illegal, and the store is kept.
  function automatic dreq_t resolve_dreq(input logic ren, input logic wen);
    dreq_t r;
    r.wr = wen;
    r.rd = ren & ~wen;
    return r;
  endfunction

endpackage

// File: rtl/request_unit_sat_counter.sv
// Saturating up-counter used for the retire and stall performance counters.
// It stops at all-ones instead of wrapping so a long run never reads as short.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Request sequencer between decode and the cache interface. It holds the PC
// until the instruction fetch and any data access have both hit, so every
// instruction retires exactly once, and keeps sticky error/timeout flags and
// retire/stall counters.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pcEN,
  output logic             halted,
  output logic             err,
  output logic             timeout,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wide enough to hold TIMEOUT itself, where the counter parks.
  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

  reqstate_t     state;
  reqstate_t     state_next;
  logic [TW-1:0] wait_cnt;
  logic          mem_op;
  dreq_t         dreq;
  logic          stall_inc;

  assign mem_op = dREN | dWEN;
  assign dreq   = resolve_dreq(dREN, dWEN);

  // Next-state, fetch request and PC enable; reset masks the strobes so
  // nothing is requested or retired while RST is high.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    imemREN    = 1'b0;
    pcEN       = 1'b0;
    unique case (state)
      FETCH: begin
        imemREN = iREN;
        if (ihit) begin
          if (halt) begin
            state_next = HALT;
          end else if (mem_op) begin
            state_next = DATA;
          end else begin
            pcEN = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pcEN       = 1'b1;
          state_next = FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    if (RST) begin
      imemREN = 1'b0;
      pcEN    = 1'b0;
    end
  end

  // State register plus the registered data requests, launched when the
  // fetch hits and dropped once the data cache answers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state   <= FETCH;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH && ihit && !halt && mem_op) begin
        dmemREN <= dreq.rd;
        dmemWEN <= dreq.wr;
      end else if (state == DATA && dhit) begin
        dmemREN <= 1'b0;
        dmemWEN <= 1'b0;
      end
    end
  end

  // Sticky status: halted from the cycle after HALT is entered, err on an
  // illegal strobe combination at fetch time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted <= 1'b0;
      err    <= 1'b0;
    end else if (state == FETCH && ihit) begin
      if (halt) begin
        halted <= 1'b1;
      end
      if ((halt && mem_op) || (!halt && dREN && dWEN)) begin
        err <= 1'b1;
      end
    end
  end

  // Data-access watchdog: counts DATA cycles without dhit, parks at TIMEOUT
  // and raises the sticky flag on the cycle it gets there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state == DATA) begin
      if (dhit) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TO_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == TO_LAST) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  // A stall is any cycle with a memory request outstanding and no retire.
  assign stall_inc = (imemREN | dmemREN | dmemWEN) & ~pcEN;

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (pcEN),
    .count (retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: a driver applies directed and random
// decode/cache stimulus, a transaction-level model predicts every output for
// each cycle and queues it, and a monitor compares the queue with the DUT.
module tb_request_unit;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
  logic             ihit = 1'b0, dhit = 1'b0;
  logic             imemREN, dmemREN, dmemWEN, pcEN, halted, err, timeout;
  logic [CNT_W-1:0] retire_cnt, stall_cnt;

  request_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .halt       (halt),
    .ihit       (ihit),
    .dhit       (dhit),
    .imemREN    (imemREN),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .pcEN       (pcEN),
    .halted     (halted),
    .err        (err),
    .timeout    (timeout),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit imem;
    bit dren;
    bit dwen;
    bit pc;
    bit halted;
    bit err;
    bit to;
    int retire;
    int stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the outstanding data access (0 none, 1 load, 2 store),
  // whether the core is parked, sticky flags, wait length and counters.
  int pend    = 0;
  bit m_halt  = 0;
  bit m_err   = 0;
  bit m_to    = 0;
  int m_wait  = 0;
  int m_ret   = 0;
  int m_stall = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of inputs, predict that cycle's outputs, advance model.
  task automatic drive(input bit rst, input bit ir, input bit dr, input bit dw,
                       input bit h, input bit ih, input bit dh);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; iREN = ir; dREN = dr; dWEN = dw; halt = h; ihit = ih; dhit = dh;
    e.imem   = !rst && !m_halt && pend == 0 && ir;
    e.dren   = (pend == 1);
    e.dwen   = (pend == 2);
    e.pc     = !rst && !m_halt &&
               ((pend == 0 && ih && !h && !dr && !dw) || (pend != 0 && dh));
    e.halted = m_halt;
    e.err    = m_err;
    e.to     = m_to;
    e.retire = m_ret;
    e.stall  = m_stall;
    sb_q.push_back(e);
    if (rst) begin
      pend = 0; m_halt = 0; m_err = 0; m_to = 0;
      m_wait = 0; m_ret = 0; m_stall = 0;
    end else begin
      if (e.pc && m_ret < CNT_MAX) m_ret++;
      if ((e.imem || e.dren || e.dwen) && !e.pc && m_stall < CNT_MAX) m_stall++;
      if (!m_halt) begin
        if (pend == 0 && ih) begin
          if (h) begin
            m_halt = 1;
            if (dr || dw) m_err = 1;
          end else if (dw) begin
            pend = 2;
            if (dr) m_err = 1;
          end else if (dr) begin
            pend = 1;
          end
        end else if (pend != 0) begin
          if (dh) begin
            pend   = 0;
            m_wait = 0;
          end else begin
            if (m_wait < TIMEOUT) m_wait++;
            if (m_wait == TIMEOUT) m_to = 1;
          end
        end
      end
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the
  // oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("imemREN",    imemREN,    e.imem);
        check("dmemREN",    dmemREN,    e.dren);
        check("dmemWEN",    dmemWEN,    e.dwen);
        check("pcEN",       pcEN,       e.pc);
        check("halted",     halted,     e.halted);
        check("err",        err,        e.err);
        check("timeout",    timeout,    e.to);
        check("retire_cnt", retire_cnt, e.retire);
        check("stall_cnt",  stall_cnt,  e.stall);
      end
    end
  end

  initial begin
    // Reset, then one ALU op that retires on its fetch hit.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0);

    // Load: a fetch miss, fetch hit, three data waits, dhit, then idle.
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Load and store together: write only, sticky err.
    drive(0, 1, 1, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 1, 0, 0, 0, 1, 0);

    // HALT: parked for ten cycles with toggling hits, one-cycle reset frees it.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, i[0], 0, 0, !i[0], i[0]);
    drive(1, 1, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 1, 0);

    // Timeout: dhit withheld past TIMEOUT, then a late hit still retires.
    drive(0, 1, 1, 0, 0, 1, 0);
    repeat (TIMEOUT + 2) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0);

    // Retire counter saturation.
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (17) drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset during a pending store abandons it.
    drive(0, 1, 0, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(59) == 0,
            $urandom_range(7) != 0,
            $urandom_range(2) == 0,
            $urandom_range(3) == 0,
            $urandom_range(39) == 0,
            $urandom_range(1) == 0,
            $urandom_range(2) == 0);
    end

    // Let the monitor drain the last prediction.
    @(negedge CLK);
    #1;
    check("scoreboard_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
